// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg: upstream side (in_*) and downstream side (out_*).
// master = the surrounding pipeline driving the buffer, slave = the buffer itself.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer (main + skid) used as a valid/ready pipeline register between datapath stages.
// Optional stall cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg #(
  parameter int WIDTH       = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  pipe_skid_reg_if.slave         bus
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             valid_q;
  logic             in_ready;
  logic             push;
  logic             pop;

  generate
    if (WIDTH < 1 || STALL_CNT_W < 1) begin : g_bad_param
      $error("pipe_skid_reg: WIDTH and STALL_CNT_W must be at least 1");
    end
  endgenerate

  // Ready depends only on registered state and reset, never on out_ready.
  assign in_ready      = reset & (state_q != FULL);
  assign push          = bus.in_valid & in_ready;
  assign pop           = valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = main_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = bus.in_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d  = bus.in_data;
        end else if (push) begin
          state_d = FULL;
          skid_d  = bus.in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Flush discards any same-cycle push; a same-cycle pop was already delivered downstream.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (valid_q && !bus.out_ready && (stall_q != STALL_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  valid_tracks_state: assert property (@(posedge clk) disable iff (!reset)
    valid_q == (state_q != EMPTY));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed table-driven bench for pipe_skid_reg plus FIFO-ordering and stall-counter sequences.
module tb_pipe_skid_reg;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt_sat;

  pipe_skid_reg_if #(.WIDTH(WIDTH)) bus_sat ();
  assign bus_sat.in_valid  = bus.in_valid;
  assign bus_sat.in_data   = bus.in_data;
  assign bus_sat.out_ready = bus.out_ready;

  pipe_skid_reg #(.WIDTH(WIDTH), .STALL_CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  pipe_skid_reg #(.WIDTH(WIDTH), .STALL_CNT_W(2)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus_sat.slave),
    .stall_cnt (stall_cnt_sat)
  );
`else
  pipe_skid_reg #(.WIDTH(WIDTH), .STALL_CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic       ir;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic rst, input logic fl, input logic iv,
                                  input logic [7:0] id, input logic ordy, input logic ov,
                                  input logic [7:0] od, input logic ir, input string name);
    vec_t v;
    v.rst  = rst;
    v.fl   = fl;
    v.iv   = iv;
    v.id   = id;
    v.ordy = ordy;
    v.ov   = ov;
    v.od   = od;
    v.ir   = ir;
    v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset         = v.rst;
    flush         = v.fl;
    bus.in_valid  = v.iv;
    bus.in_data   = v.id;
    bus.out_ready = v.ordy;
  endtask

  task automatic check_output(input vec_t v);
    check_val({v.name, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v.ov});
    check_val({v.name, ".out_data"},  {24'd0, bus.out_data},  {24'd0, v.od});
    check_val({v.name, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, v.ir});
  endtask

  // Streams eight values through under an irregular out_ready pattern; a queue holds the expected order.
  task automatic fifo_sequence();
    logic [7:0]  exp_q[$];
    logic [15:0] rdy_pat = 16'b1011_0010_1110_0101;
    int          sent = 0;
    int          recv = 0;
    int          cyc = 0;
    logic        push_now;
    logic        pop_now;
    reset = 1'b1;
    flush = 1'b0;
    while (recv < 8 && cyc < 200) begin
      bus.in_valid  = (sent < 8);
      bus.in_data   = 8'h40 + 8'(sent);
      bus.out_ready = rdy_pat[cyc % 16];
      #1;
      push_now = bus.in_valid & bus.in_ready;
      pop_now  = bus.out_valid & bus.out_ready;
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL fifo.spurious: got data %0h, expected no valid output", bus.out_data);
        end else begin
          check_val("fifo.order", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
          recv++;
        end
      end
      if (push_now) begin
        exp_q.push_back(bus.in_data);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_val("fifo.count", recv, 8);
    check_val("fifo.drained", {31'd0, bus.out_valid}, 32'd0);
  endtask

`ifdef PIPE_STALL_CNT_EN
  task automatic stall_sequence();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_val("stall.cleared", {16'd0, stall_cnt}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_val("stall.count5", {16'd0, stall_cnt}, 32'd5);
    check_val("stall.saturate", {30'd0, stall_cnt_sat}, 32'd3);
    check_val("stall.sat_data", {24'd0, bus_sat.out_data}, 32'h55);
    check_val("stall.sat_ready", {31'd0, bus_sat.in_ready}, 32'd1);
    check_val("stall.sat_valid", {31'd0, bus_sat.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_val("stall.hold", {16'd0, stall_cnt}, 32'd5);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_val("stall.flush", {16'd0, stall_cnt}, 32'd0);
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    //       rst fl iv id     ordy ov od     ir name
    add_vec(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, "reset_hold");
    add_vec(1, 0, 0, 8'h00, 1, 0, 8'h00, 1, "reset_release");
    add_vec(1, 0, 1, 8'h11, 1, 0, 8'h00, 1, "push_11");
    add_vec(1, 0, 1, 8'h22, 1, 1, 8'h11, 1, "push_22");
    add_vec(1, 0, 1, 8'h33, 1, 1, 8'h22, 1, "push_33");
    add_vec(1, 0, 0, 8'h00, 1, 1, 8'h33, 1, "drain_33");
    add_vec(1, 0, 0, 8'h00, 0, 0, 8'h33, 1, "idle_hold");
    add_vec(1, 0, 1, 8'hA5, 0, 0, 8'h33, 1, "push_a5");
    add_vec(1, 0, 1, 8'h5A, 0, 1, 8'hA5, 1, "push_5a");
    add_vec(1, 0, 0, 8'h00, 0, 1, 8'hA5, 0, "full_stall");
    add_vec(1, 0, 0, 8'h00, 1, 1, 8'hA5, 0, "pop_a5");
    add_vec(1, 0, 0, 8'h00, 1, 1, 8'h5A, 1, "pop_5a");
    add_vec(1, 0, 1, 8'h01, 0, 0, 8'h5A, 1, "fill_01");
    add_vec(1, 0, 1, 8'h02, 0, 1, 8'h01, 1, "fill_02");
    add_vec(1, 1, 1, 8'h77, 0, 1, 8'h01, 0, "flush_full");
    add_vec(1, 0, 0, 8'h00, 1, 0, 8'h00, 1, "after_flush");
    add_vec(1, 1, 1, 8'h99, 1, 0, 8'h00, 1, "flush_push");
    add_vec(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, "push_dropped");
    add_vec(1, 0, 1, 8'h10, 0, 0, 8'h00, 1, "push_10");
    add_vec(1, 0, 1, 8'h20, 1, 1, 8'h10, 1, "push_pop_20");
    add_vec(1, 0, 0, 8'h00, 0, 1, 8'h20, 1, "hold_20");
    add_vec(1, 0, 0, 8'h00, 1, 1, 8'h20, 1, "pop_20");
    add_vec(1, 0, 0, 8'h00, 0, 0, 8'h20, 1, "no_dup");
    add_vec(1, 0, 1, 8'hAB, 0, 0, 8'h20, 1, "push_ab");
    add_vec(0, 0, 0, 8'h00, 0, 1, 8'hAB, 0, "mid_reset");
    add_vec(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, "post_reset");

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output(vecs[i]);
      @(posedge clk);
      #1;
    end

    fifo_sequence();
`ifdef PIPE_STALL_CNT_EN
    stall_sequence();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
